// File: rtl/sram_wb_pkg.sv
// Shared constants for the Wishbone-to-SRAM (1rw1r macro) controller.
// Holds the address-decode geometry, SRAM port widths and FSM state encodings.
package sram_wb_pkg;

    // Byte address bits below the word address
    localparam int unsigned WORD_LSB    = 2;
    // log2 of the 1 KiB Wishbone window
    localparam int unsigned WINDOW_BITS = 10;

    // SRAM macro port geometry
    localparam int unsigned SRAM_DATA_W = 32;
    localparam int unsigned SRAM_MASK_W = SRAM_DATA_W / 8;
    localparam int unsigned SRAM_ADDR_W = 8;

    // Wishbone-side FSM states
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_RWAIT = 2'd2;
    localparam state_t ST_ACK   = 2'd3;

    // Port-1 reader FSM states
    localparam state_t RD_IDLE  = 2'd0;
    localparam state_t RD_ISSUE = 2'd1;
    localparam state_t RD_WAIT  = 2'd2;
    localparam state_t RD_VALID = 2'd3;

endpackage

// File: rtl/sram_wb_port1_rd.sv
// Auxiliary reader on the macro's read-only port 1.
// A request is taken only when idle; requests arriving while busy are dropped.
// rd_valid_o pulses for one cycle carrying the word read.
module sram_wb_port1_rd
    import sram_wb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  rd_req_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic                  rd_valid_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  sram_csb1_o,
    output logic [ADDR_WIDTH-1:0] sram_addr1_o,
    input  logic [DATA_WIDTH-1:0] sram_dout1_i
);

    state_t state_q;

    // Issue, wait for the macro's registered output, then present it for one cycle
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= RD_IDLE;
            sram_csb1_o  <= 1'b1;
            sram_addr1_o <= '0;
            rd_valid_o   <= 1'b0;
            rd_data_o    <= '0;
        end else begin
            case (state_q)
                RD_IDLE: begin
                    if (rd_req_i) begin
                        sram_csb1_o  <= 1'b0;
                        sram_addr1_o <= rd_addr_i;
                        state_q      <= RD_ISSUE;
                    end
                end
                RD_ISSUE: begin
                    sram_csb1_o <= 1'b1;
                    state_q     <= RD_WAIT;
                end
                RD_WAIT: begin
                    rd_valid_o <= 1'b1;
                    rd_data_o  <= sram_dout1_i;
                    state_q    <= RD_VALID;
                end
                RD_VALID: begin
                    rd_valid_o <= 1'b0;
                    state_q    <= RD_IDLE;
                end
                default: state_q <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sram_wb_ctrl.sv
// Wishbone classic slave mapping a 1 KiB window onto a 1rw1r SRAM macro.
// Port 0 (RW) serves the bus; port 1 (R) is either idle or, when the macro
// SRAM_WB_PORT1_EN is defined, driven by the sram_wb_port1_rd side reader.
// All port-0 outputs are registered so the macro sees clean, flop-driven inputs.
module sram_wb_ctrl
    import sram_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_we_i,
    input  logic [DATA_WIDTH/8-1:0] wbs_sel_i,
    input  logic [31:0]             wbs_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
    output logic                    wbs_ack_o,
    output logic [DATA_WIDTH-1:0]   wbs_dat_o,
    output logic                    sram_csb0,
    output logic                    sram_web0,
    output logic [DATA_WIDTH/8-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0]   sram_addr0,
    output logic [DATA_WIDTH-1:0]   sram_din0,
    input  logic [DATA_WIDTH-1:0]   sram_dout0,
    output logic                    sram_csb1,
    output logic [ADDR_WIDTH-1:0]   sram_addr1,
    input  logic [DATA_WIDTH-1:0]   sram_dout1
`ifdef SRAM_WB_PORT1_EN
    ,
    input  logic                    rd_req_i,
    input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
    output logic                    rd_valid_o,
    output logic [DATA_WIDTH-1:0]   rd_data_o
`endif
);

    state_t                state_q;
    logic                  hit;
    logic [ADDR_WIDTH-1:0] word_addr;

    // Window decode; byte offset within the word is ignored
    always_comb begin
        hit       = wbs_cyc_i && wbs_stb_i &&
                    (wbs_adr_i[31:WINDOW_BITS] == BASE_ADDR[31:WINDOW_BITS]);
        word_addr = wbs_adr_i[WORD_LSB +: ADDR_WIDTH];
    end

    logic unused_byte_offset;
    assign unused_byte_offset = ^wbs_adr_i[WORD_LSB-1:0];

    // Bus FSM: issue one macro access per strobe, ack once, then rest a cycle
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= '0;
            sram_csb0   <= 1'b1;
            sram_web0   <= 1'b1;
            sram_wmask0 <= '0;
            sram_addr0  <= '0;
            sram_din0   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hit) begin
                        sram_csb0   <= 1'b0;
                        sram_web0   <= ~wbs_we_i;
                        sram_wmask0 <= wbs_sel_i;
                        sram_addr0  <= word_addr;
                        sram_din0   <= wbs_dat_i;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Macro samples at this edge; web0 still tells us the direction
                    sram_csb0 <= 1'b1;
                    if (!sram_web0) begin
                        wbs_ack_o <= wbs_cyc_i;
                        state_q   <= ST_ACK;
                    end else begin
                        state_q <= ST_RWAIT;
                    end
                end
                ST_RWAIT: begin
                    wbs_dat_o <= sram_dout0;
                    wbs_ack_o <= wbs_cyc_i;
                    state_q   <= ST_ACK;
                end
                ST_ACK: begin
                    // Strobe is ignored here so a held strobe is not reissued
                    wbs_ack_o <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef SRAM_WB_PORT1_EN
    sram_wb_port1_rd #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_port1_rd (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_i     (wb_rst_i),
        .rd_req_i     (rd_req_i),
        .rd_addr_i    (rd_addr_i),
        .rd_valid_o   (rd_valid_o),
        .rd_data_o    (rd_data_o),
        .sram_csb1_o  (sram_csb1),
        .sram_addr1_o (sram_addr1),
        .sram_dout1_i (sram_dout1)
    );
`else
    assign sram_csb1  = 1'b1;
    assign sram_addr1 = '0;

    logic [DATA_WIDTH-1:0] unused_dout1;
    assign unused_dout1 = sram_dout1;
`endif

endmodule

// File: doc/sram_wb_ctrl.md
SRAM_WB_CTRL -- requirements
Module: sram_wb_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone base address of the 1 KiB window.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, SRAM word-address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, word width; byte-lane count = DATA_WIDTH/8.
REQ-004 SHALL have port wb_clk_i  in  1  single clock for the bus side and both SRAM ports.
REQ-005 SHALL have port wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports wbs_cyc_i/wbs_stb_i/wbs_we_i  in  1 each  Wishbone classic cycle, strobe, write enable.
REQ-007 SHALL have ports wbs_sel_i  in  4, wbs_adr_i  in  32, wbs_dat_i  in  32  byte select, byte address, write data.
REQ-008 SHALL have ports wbs_ack_o  out  1, wbs_dat_o  out  32  acknowledge, read data.
REQ-009 SHALL have ports sram_csb0/sram_web0  out  1, sram_wmask0  out  4, sram_addr0  out  ADDR_WIDTH, sram_din0  out  32, sram_dout0  in  32  drives the macro's RW port; all outputs are flops.
REQ-010 SHALL have ports sram_csb1  out  1, sram_addr1  out  ADDR_WIDTH, sram_dout1  in  32  drives the macro's R port.

Function
REQ-011 SHALL decode a hit when wbs_cyc_i & wbs_stb_i & wbs_adr_i[31:10]==BASE_ADDR[31:10]; word address = wbs_adr_i[9:2]; bits [1:0] ignored.
REQ-012 SHALL implement FSM IDLE -> ISSUE -> (write: ACK | read: RWAIT -> ACK) -> IDLE.
REQ-013 IDLE: on hit at edge E0, SHALL register csb0=0, web0=~wbs_we_i, wmask0=wbs_sel_i, addr0, din0; go ISSUE.
REQ-014 ISSUE: at E1 the macro samples its inputs; SHALL set csb0=1; write goes ACK with wbs_ack_o=1, read goes RWAIT.
REQ-015 RWAIT: at E2 SHALL capture sram_dout0 into wbs_dat_o, set wbs_ack_o=1, go ACK.
REQ-016 ACK: SHALL hold ack for exactly one cycle, ignore stb, clear ack and return to IDLE; no back-to-back reissue of the same strobe.
REQ-017 Latency: write ack high in cycle after E1 (2 cycles); read ack high in cycle after E2 (3 cycles).
REQ-018 wbs_dat_o SHALL hold the last read word until the next read capture; write cycles SHALL not alter it.
REQ-019 wbs_sel_i==0 write SHALL issue with wmask0=0 (no memory change) and still ack.
REQ-020 cyc dropped mid-transfer: SRAM access SHALL complete, ack SHALL be suppressed if wbs_cyc_i==0 at the ack edge; FSM still returns to IDLE.
REQ-021 Non-hit strobes SHALL produce no SRAM access and no ack.

Reset
REQ-022 On wb_rst_i high (immediately, asynchronous): state=IDLE, wbs_ack_o=0, wbs_dat_o=0, sram_csb0=1, sram_web0=1, sram_wmask0=0, sram_addr0=0, sram_din0=0, sram_csb1=1, sram_addr1=0.
REQ-023 Reset during ISSUE/RWAIT SHALL abort the transfer with no ack; the first post-reset hit SHALL be handled normally.

Configuration
REQ-024 Macro SRAM_WB_PORT1_EN: when defined, SHALL add ports rd_req_i in 1, rd_addr_i in ADDR_WIDTH, rd_valid_o out 1, rd_data_o out 32; rd_req_i at E0 registers csb1=0/addr1, csb1=1 at E1, rd_valid_o=1 for one cycle after E2 with rd_data_o=sram_dout1; requests while busy SHALL be dropped.
REQ-025 Without SRAM_WB_PORT1_EN: rd_* ports SHALL not exist; sram_csb1 constant 1, sram_addr1 constant 0.

Structure
REQ-026 Package sram_wb_pkg SHALL hold the FSM state enum, WORD_LSB=2, WINDOW_BITS=10, and the SRAM port width constants.
REQ-027 Port-1 reader SHALL be sub-module sram_wb_port1_rd, instantiated only under SRAM_WB_PORT1_EN.

Verification (bench uses the behavioural 1rw1r macro model)
REQ-028 Write 0x3000_0010 data 0xDEADBEEF sel 4'hF, then read -> ack 2 cycles after write strobe, read ack 3 cycles after strobe, wbs_dat_o=0xDEADBEEF.
REQ-029 Write 0x11223344 to word 4, then sel 4'b0010 write 0x0000AA00, read -> 0x1122AA44.
REQ-030 Strobe at 0x3000_0400 (outside window) -> sram_csb0 stays 1, no ack for 10 cycles.
REQ-031 Assert wb_rst_i during RWAIT -> ack never rises, sram_csb0=1 same cycle; next read of word 4 returns 0x1122AA44 in 3 cycles.
REQ-032 Back-to-back reads of words 0 and 255 with stb held -> two acks, each single-cycle, wrap-edge address 255 correct.
REQ-033 With SRAM_WB_PORT1_EN: rd_req_i addr 4 concurrent with Wishbone write to word 8 -> rd_valid_o after E2, rd_data_o=0x1122AA44, write unaffected.
